// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU op codes, RV32I opcodes and the decoded control struct
//
// Imported by alu_decoder, alu_ctrl_stage and the ALU itself, so the op codes
// driven on ex_alu_control are the same constants the ALU decodes.

package alu_pkg;

  // ALU operation codes carried on ex_alu_control
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  // RV32I major opcodes handled by this stage
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;

  // Decoded datapath controls, registered as one unit at the ID/EX boundary
  typedef struct packed {
    logic [2:0] alu_control;
    logic       alu_src;
    logic       reg_write;
    logic       mem_write;
    logic       result_src;
    logic       branch;
  } alu_ctrl_t;

endpackage

// File: rtl/alu_ctrl_stage_if.sv
// rtl/alu_ctrl_stage_if.sv - ID-side input and EX-side output bundle of the ALU control stage
//
// Signals:
//   id_valid / id_ready / id_instr / id_pc : instruction in from fetch/decode
//   flush                                  : kill registered and incoming instruction
//   ex_valid / ex_ready                    : handshake toward execute
//   ex_alu_control, ex_alu_src, ex_reg_write, ex_mem_write,
//   ex_result_src, ex_branch, ex_rd, ex_pc : registered controls
//   illegal                                : one-cycle pulse on a dropped instruction
// Modports:
//   master : the stage (drives id_ready and all ex_* outputs)
//   slave  : the surrounding pipeline

interface alu_ctrl_stage_if #(
  parameter int XLEN = 32
);

  logic            id_valid;
  logic            id_ready;
  logic [31:0]     id_instr;
  logic [XLEN-1:0] id_pc;
  logic            flush;
  logic            ex_valid;
  logic            ex_ready;
  logic [2:0]      ex_alu_control;
  logic            ex_alu_src;
  logic            ex_reg_write;
  logic            ex_mem_write;
  logic            ex_result_src;
  logic            ex_branch;
  logic [4:0]      ex_rd;
  logic [XLEN-1:0] ex_pc;
  logic            illegal;

  modport master (
    input  id_valid, id_instr, id_pc, flush, ex_ready,
    output id_ready, ex_valid, ex_alu_control, ex_alu_src, ex_reg_write,
           ex_mem_write, ex_result_src, ex_branch, ex_rd, ex_pc, illegal
  );

  modport slave (
    output id_valid, id_instr, id_pc, flush, ex_ready,
    input  id_ready, ex_valid, ex_alu_control, ex_alu_src, ex_reg_write,
           ex_mem_write, ex_result_src, ex_branch, ex_rd, ex_pc, illegal
  );

endinterface

// File: rtl/alu_ctrl_stage_decoder.sv
// rtl/alu_ctrl_stage_decoder.sv - combinational RV32I decode to ALU control struct
//
// Ports:
//   instr       in  32 : instruction word
//   ctrl        out    : decoded controls (all zero / add when unsupported)
//   unsupported out 1  : opcode or funct3 not handled by this stage

module alu_decoder
  import alu_pkg::*;
(
  input  logic [31:0] instr,
  output alu_ctrl_t   ctrl,
  output logic        unsupported
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       unused_bits;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  // rd is taken directly by the stage; the rest only matters to other units
  assign unused_bits = ^{instr[31], instr[29:15], instr[11:7]};

  always_comb begin
    ctrl        = '0;
    unsupported = 1'b0;
    case (opcode)
      OP_LOAD: begin
        ctrl.alu_src    = 1'b1;
        ctrl.reg_write  = 1'b1;
        ctrl.result_src = 1'b1;
      end
      OP_STORE: begin
        ctrl.alu_src   = 1'b1;
        ctrl.mem_write = 1'b1;
      end
      OP_BRANCH: begin
        ctrl.alu_control = ALU_SUB;
        ctrl.branch      = 1'b1;
      end
      OP_REG, OP_IMM: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = ~instr[5];
        case (funct3)
          // instr[5] separates R-type from I-ALU, so addi with imm bit 30 set stays add
          3'b000:  ctrl.alu_control = (instr[5] & instr[30]) ? ALU_SUB : ALU_ADD;
          3'b010:  ctrl.alu_control = ALU_SLT;
          3'b110:  ctrl.alu_control = ALU_OR;
          3'b111:  ctrl.alu_control = ALU_AND;
          default: unsupported = 1'b1;
        endcase
      end
      default: unsupported = 1'b1;
    endcase
    // Unsupported instructions degrade to a harmless add with no side effects
    if (unsupported) begin
      ctrl = '0;
    end
  end

endmodule

// File: rtl/alu_ctrl_stage.sv
// rtl/alu_ctrl_stage.sv - ID/EX register for ALU controls with valid/ready, stall and flush
//
// Ports:
//   clk : clock, rising edge
//   rst : asynchronous active-low reset
//   bus : alu_ctrl_stage_if.master (id_* in, ex_* out, flush, illegal)
// Parameters:
//   XLEN : PC width
// Build option:
//   ALU_CTRL_ILLEGAL_EN : unsupported instructions become bubbles and pulse illegal;
//                         otherwise they pass as add with no writes and illegal is 0.

module alu_ctrl_stage #(
  parameter int XLEN = 32
) (
  input  logic              clk,
  input  logic              rst,
  alu_ctrl_stage_if.master  bus
);

  import alu_pkg::*;

  alu_ctrl_t       dec_ctrl;
  logic            dec_unsupported;
  alu_ctrl_t       ctrl_q;
  logic            valid_q;
  logic [4:0]      rd_q;
  logic [XLEN-1:0] pc_q;
  logic            accept;
  logic            load_ok;

  alu_decoder u_decoder (
    .instr       (bus.id_instr),
    .ctrl        (dec_ctrl),
    .unsupported (dec_unsupported)
  );

  assign bus.id_ready = ~valid_q | bus.ex_ready;
  assign accept       = bus.id_valid & bus.id_ready;

`ifdef ALU_CTRL_ILLEGAL_EN
  logic illegal_q;

  assign load_ok     = ~dec_unsupported;
  assign bus.illegal = illegal_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      illegal_q <= 1'b0;
    end else begin
      // flush in the accept cycle swallows the report along with the instruction
      illegal_q <= accept & dec_unsupported & ~bus.flush;
    end
  end
`else
  logic unused_unsupported;

  assign unused_unsupported = dec_unsupported;
  assign load_ok            = 1'b1;
  assign bus.illegal        = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      rd_q    <= '0;
      pc_q    <= '0;
    end else if (bus.flush) begin
      valid_q <= 1'b0;
    end else if (accept) begin
      // a dropped instruction still empties the slot when the old entry leaves
      valid_q <= load_ok;
      if (load_ok) begin
        ctrl_q <= dec_ctrl;
        rd_q   <= bus.id_instr[11:7];
        pc_q   <= bus.id_pc;
      end
    end else if (bus.ex_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign bus.ex_valid       = valid_q;
  assign bus.ex_alu_control = ctrl_q.alu_control;
  assign bus.ex_alu_src     = ctrl_q.alu_src;
  assign bus.ex_result_src  = ctrl_q.result_src;
  // state-changing controls are gated so a bubble can never write
  assign bus.ex_reg_write   = valid_q & ctrl_q.reg_write;
  assign bus.ex_mem_write   = valid_q & ctrl_q.mem_write;
  assign bus.ex_branch      = valid_q & ctrl_q.branch;
  assign bus.ex_rd          = rd_q;
  assign bus.ex_pc          = pc_q;

endmodule

// File: tb/tb_alu_ctrl_stage.sv
// tb/tb_alu_ctrl_stage.sv - self-checking bench for alu_ctrl_stage

module tb_alu_ctrl_stage;

  localparam int XLEN = 32;
`ifdef ALU_CTRL_ILLEGAL_EN
  localparam bit ILL_EN = 1'b1;
`else
  localparam bit ILL_EN = 1'b0;
`endif

  typedef struct packed {
    logic       ok;
    logic [2:0] alu;
    logic       src;
    logic       rw;
    logic       mw;
    logic       rs;
    logic       br;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  // reference state: the instruction occupying the EX slot
  logic        m_valid   = 1'b0;
  logic [31:0] m_instr   = '0;
  logic [31:0] m_pc      = '0;
  logic        m_illegal = 1'b0;

  alu_ctrl_stage_if #(.XLEN(XLEN)) bus ();

  alu_ctrl_stage #(.XLEN(XLEN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // RV32I subset semantics taken straight from the instruction tables
  function automatic exp_t ref_decode(input logic [31:0] ins);
    exp_t       e;
    logic [6:0] op;
    logic [2:0] f3;
    op   = ins[6:0];
    f3   = ins[14:12];
    e    = '0;
    e.ok = 1'b1;
    if (op == 7'b0000011) begin
      e.src = 1; e.rw = 1; e.rs = 1;
    end else if (op == 7'b0100011) begin
      e.src = 1; e.mw = 1;
    end else if (op == 7'b1100011) begin
      e.alu = 3'b001; e.br = 1;
    end else if (op == 7'b0110011 || op == 7'b0010011) begin
      e.rw  = 1;
      e.src = (op == 7'b0010011);
      if (f3 == 3'd0)      e.alu = (op == 7'b0110011 && ins[30]) ? 3'b001 : 3'b000;
      else if (f3 == 3'd2) e.alu = 3'b101;
      else if (f3 == 3'd6) e.alu = 3'b011;
      else if (f3 == 3'd7) e.alu = 3'b010;
      else                 e.ok  = 1'b0;
    end else begin
      e.ok = 1'b0;
    end
    if (!e.ok) e = '0;
    return e;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    logic [6:0]  op;
    r = $urandom();
    case ($urandom_range(0, 6))
      0:       op = 7'b0000011;
      1:       op = 7'b0100011;
      2:       op = 7'b1100011;
      3, 4:    op = 7'b0110011;
      5:       op = 7'b0010011;
      default: op = 7'($urandom());
    endcase
    return {r[31:7], op};
  endfunction

  // one clock: drive after negedge, check id_ready, advance model at posedge, check outputs
  task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                      input logic rdy, input logic fl);
    logic  acc;
    exp_t  e;
    bus.id_valid = v;
    bus.id_instr = ins;
    bus.id_pc    = pc;
    bus.ex_ready = rdy;
    bus.flush    = fl;
    #1;
    check("id_ready", bus.id_ready, !m_valid || rdy);
    @(posedge clk);
    acc       = v && (!m_valid || rdy);
    m_illegal = 1'b0;
    if (fl) begin
      m_valid = 1'b0;
    end else if (acc) begin
      if (ref_decode(ins).ok || !ILL_EN) begin
        m_valid = 1'b1;
        m_instr = ins;
        m_pc    = pc;
      end else begin
        m_valid   = 1'b0;
        m_illegal = 1'b1;
      end
    end else if (rdy) begin
      m_valid = 1'b0;
    end
    #1;
    e = ref_decode(m_instr);
    check("ex_valid", bus.ex_valid, m_valid);
    check("illegal", bus.illegal, m_illegal);
    check("reg_write", bus.ex_reg_write, m_valid & e.rw);
    check("mem_write", bus.ex_mem_write, m_valid & e.mw);
    check("branch", bus.ex_branch, m_valid & e.br);
    if (m_valid) begin
      check("alu_control", bus.ex_alu_control, e.alu);
      check("alu_src", bus.ex_alu_src, e.src);
      check("result_src", bus.ex_result_src, e.rs);
      check("rd", bus.ex_rd, m_instr[11:7]);
      check("pc", bus.ex_pc, m_pc);
    end
    @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ex_valid"}, bus.ex_valid, 0);
    check({tag, "_alu_control"}, bus.ex_alu_control, 0);
    check({tag, "_alu_src"}, bus.ex_alu_src, 0);
    check({tag, "_reg_write"}, bus.ex_reg_write, 0);
    check({tag, "_mem_write"}, bus.ex_mem_write, 0);
    check({tag, "_result_src"}, bus.ex_result_src, 0);
    check({tag, "_branch"}, bus.ex_branch, 0);
    check({tag, "_rd"}, bus.ex_rd, 0);
    check({tag, "_pc"}, bus.ex_pc, 0);
    check({tag, "_illegal"}, bus.illegal, 0);
  endtask

  initial begin
    bus.id_valid = 1'b0;
    bus.id_instr = '0;
    bus.id_pc    = '0;
    bus.ex_ready = 1'b0;
    bus.flush    = 1'b0;
    #2;
    check_all_zero("reset");
    @(negedge clk);
    rst = 1'b1;

    // directed vectors
    step(1, 32'h002081B3, 32'h100, 1, 0);
    check("add_alu", bus.ex_alu_control, 3'b000);
    check("add_rw", bus.ex_reg_write, 1);
    check("add_rd", bus.ex_rd, 3);
    step(1, 32'h402081B3, 32'h104, 1, 0);
    check("sub_alu", bus.ex_alu_control, 3'b001);
    step(1, 32'h0020A1B3, 32'h108, 1, 0);
    check("slt_alu", bus.ex_alu_control, 3'b101);
    step(1, 32'hFFF00093, 32'h10C, 1, 0);
    check("addi_alu", bus.ex_alu_control, 3'b000);
    check("addi_src", bus.ex_alu_src, 1);
    step(1, 32'h00208463, 32'h110, 1, 0);
    check("beq_alu", bus.ex_alu_control, 3'b001);
    check("beq_branch", bus.ex_branch, 1);
    check("beq_rw", bus.ex_reg_write, 0);
    for (int i = 0; i < 3; i++) begin
      step(1, 32'h002081B3, 32'h200, 0, 0);
      check("stall_id_ready", bus.id_ready, 0);
      check("stall_pc", bus.ex_pc, 32'h110);
      check("stall_branch", bus.ex_branch, 1);
    end
    step(1, 32'h002081B3, 32'h114, 1, 1);
    check("flush_valid", bus.ex_valid, 0);
    check("flush_rw", bus.ex_reg_write, 0);
    step(1, 32'h002081B3, 32'h118, 1, 0);
    step(1, 32'h402081B3, 32'h11C, 1, 0);
    check("b2b_valid", bus.ex_valid, 1);
    check("b2b_pc", bus.ex_pc, 32'h11C);
    step(1, 32'h002091B3, 32'h120, 1, 0);
    check("sll_valid", bus.ex_valid, !ILL_EN);
    check("sll_illegal", bus.illegal, ILL_EN);
    check("sll_rw", bus.ex_reg_write, 0);
    if (!ILL_EN) check("sll_alu", bus.ex_alu_control, 3'b000);
    step(0, 32'h0, 32'h0, 1, 0);
    check("sll_pulse_end", bus.illegal, 0);

    // reset in the middle of a stall
    step(1, 32'h00208463, 32'h124, 1, 0);
    step(0, 32'h0, 32'h0, 0, 0);
    rst = 1'b0;
    #1;
    check_all_zero("midstall_reset");
    m_valid   = 1'b0;
    m_illegal = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    step(0, 32'h0, 32'h0, 0, 0);

    // randomized traffic against the reference
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 3) != 0), rand_instr(), $urandom(),
           1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 19) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/alu_ctrl_stage.md
# alu_ctrl_stage

Produces the `ALUControl` code and datapath control bits that drive the ALU. It decodes a fetched RV32I instruction and registers the result into the ID/EX boundary behind an elastic valid/ready handshake. It sits between the fetch/decode register and the execute stage, and is the producing end of the ALU's control interface. It owns stall hold, flush-to-bubble and illegal-instruction detection.

## Interface
Parameters:
- `XLEN`, 32: width of the PC passthrough.

Ports:
- `clk` in 1: single clock; all state on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `id_valid` in 1: `id_instr`/`id_pc` carry a valid instruction.
- `id_ready` out 1: stage accepts this cycle.
- `id_instr` in 32: instruction word.
- `id_pc` in XLEN: instruction PC.
- `flush` in 1: kill the registered instruction and any input accepted this cycle.
- `ex_valid` out 1: registered outputs valid.
- `ex_ready` in 1: execute consumes this cycle.
- `ex_alu_control` out 3: ALU op code (000 add, 001 sub, 010 and, 011 or, 101 slt).
- `ex_alu_src` out 1: 1 selects the immediate as ALU operand B.
- `ex_reg_write`, `ex_mem_write`, `ex_result_src`, `ex_branch` out 1 each: datapath controls.
- `ex_rd` out 5: destination register (`instr[11:7]`).
- `ex_pc` out XLEN: registered PC.
- `illegal` out 1: one-cycle pulse when an unsupported instruction is dropped.

## Operation
- Supported opcodes:
  - lw 0000011: add, alu_src=1, reg_write=1, result_src=1.
  - sw 0100011: add, alu_src=1, mem_write=1.
  - beq 1100011: sub, branch=1.
  - R-type 0110011 and I-ALU 0010011: reg_write=1; alu_src=1 for I-ALU only.
- R-type and I-ALU funct3 mapping:
  - 000 → sub only when `{instr[5],instr[30]}`==11, otherwise add.
  - 010 → 101 (slt).
  - 110 → 011 (or).
  - 111 → 010 (and).
- Any other opcode, or any other funct3 in R-type/I-ALU, is unsupported; handling depends on the configuration below.
- Handshake:
  - `id_ready = ~ex_valid | ex_ready`.
  - An accept is `id_valid & id_ready`.
  - An accept loads all `ex_*` registers.
  - A consume without an accept clears `ex_valid`.
- Stall: while `ex_valid & ~ex_ready`, every `ex_*` output holds bit-stable.
- Flush: has priority over accept and over stall. Next cycle `ex_valid`=0, and whatever was presented that cycle is lost.
- Bubble rule: `ex_reg_write`, `ex_mem_write` and `ex_branch` are forced to 0 whenever `ex_valid`=0, so a bubble can never write state.

## Timing
- Latency: 1 cycle from accept to `ex_valid`.
- Throughput: one instruction per cycle while `ex_ready`=1.
- Reset: all outputs 0; `ex_alu_control`=000, `ex_pc`=0. `id_ready`=1 from the first cycle after reset release.
- Reset asserted mid-stall drops the held instruction immediately, with no pulse.
- `illegal` is registered. It asserts the cycle after the dropping accept, for one cycle, and is suppressed if `flush` is high in the accept cycle.
- Simultaneous consume + accept: the new instruction replaces the old one with no bubble.

## Configuration
- `ALU_CTRL_ILLEGAL_EN` defined:
  - An unsupported instruction is accepted but produces a bubble (`ex_valid` stays 0, or becomes 0 if the old entry is consumed).
  - `illegal` pulses.
- `ALU_CTRL_ILLEGAL_EN` undefined:
  - An unsupported instruction passes through as add with all write/branch controls 0.
  - `illegal` is tied to 0.

## Structure
- Shared package `alu_pkg`:
  - ALU op localparams (`ALU_ADD`, `ALU_SUB`, `ALU_AND`, `ALU_OR`, `ALU_SLT`).
  - Opcode constants.
  - A packed control struct.
  - The ALU consumes the same op constants.
- One combinational sub-module `alu_decoder` maps `instr` to the control struct plus an unsupported flag. The top holds only the register and handshake logic.

## Test plan
- `0x002081B3` (add x3,x1,x2), `ex_ready`=1 → next cycle `ex_valid`=1, alu_control 000, reg_write 1, rd 3.
- `0x402081B3` (sub) → 001. `0x0020A1B3` (slt) → 101. `0xFFF00093` (addi -1, bit30 set) → 000 with alu_src 1.
- `0x00208463` (beq) → 001, branch 1, reg_write 0. Then hold `ex_ready`=0 for 3 cycles → outputs stable, `id_ready`=0, and a new `id_valid` is not accepted.
- `flush` in the same cycle as accepting `0x002081B3` → next cycle `ex_valid`=0 and reg_write 0. Back-to-back accepts with `ex_ready`=1 → no bubbles.
- `0x002091B3` (sll):
  - With `ALU_CTRL_ILLEGAL_EN`: `illegal` pulses 1 cycle, `ex_valid`=0.
  - Without it: `ex_valid`=1, alu_control 000, reg_write 0.
- Assert `rst`=0 mid-stall → all outputs 0 asynchronously. After release → `id_ready`=1.
